hazard_scoreboard: RTL and testbench

//  Parametrised successor to the CPU's fixed curr_rd/we_bypass/we_stall flag handshake.
//  Per-register scoreboard sits beside decode and tracks in-flight writes by age and by result latency.
//  Per issue slot it produces a stall and a per-source forwarding-stage select.

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 65 ++++++
 tb/tb_hazard_scoreboard.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: issue/forwarding bundle between decode (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int NREGS      = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int MAX_LAT    = 3
);
    localparam int RA_W  = $clog2(NREGS);
    localparam int STG_W = $clog2(PIPE_DEPTH + 1);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    logic             iss_valid;
    logic [RA_W-1:0]  iss_rs1;
    logic             iss_rs1_use;
    logic [RA_W-1:0]  iss_rs2;
    logic             iss_rs2_use;
    logic [RA_W-1:0]  iss_rd;
    logic             iss_we;
    logic [LAT_W-1:0] iss_lat;
    logic             flush;
    logic             iss_ready;
    logic             stall;
    logic [STG_W-1:0] fwd_rs1_sel;
    logic [STG_W-1:0] fwd_rs2_sel;
    logic [31:0]      stall_cnt;
    modport master (
        output iss_valid, iss_rs1, iss_rs1_use, iss_rs2, iss_rs2_use, iss_rd, iss_we, iss_lat, flush,
        input  iss_ready, stall, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
    );
    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_use, iss_rs2, iss_rs2_use, iss_rd, iss_we, iss_lat, flush,
        output iss_ready, stall, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register in-flight write tracker giving stall and forwarding-stage selects.
// Optional stall-cycle counter enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int NREGS      = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int MAX_LAT    = 3,
    parameter int FLUSH_AGE  = 1
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int RA_W  = $clog2(NREGS);
    localparam int STG_W = $clog2(PIPE_DEPTH + 1);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    logic [STG_W-1:0] age_q [NREGS];
    logic [STG_W-1:0] age_d [NREGS];
    logic [LAT_W-1:0] cnt_q [NREGS];
    logic [LAT_W-1:0] cnt_d [NREGS];
    logic             hit1, hit2, blk1, blk2, go, accept;
    logic [LAT_W-1:0] lat_sat;
    always_comb begin
        hit1 = bus.iss_rs1_use && bus.iss_rs1 != '0 && age_q[bus.iss_rs1] != '0;
        hit2 = bus.iss_rs2_use && bus.iss_rs2 != '0 && age_q[bus.iss_rs2] != '0;
        blk1 = hit1 && cnt_q[bus.iss_rs1] != '0;
        blk2 = hit2 && cnt_q[bus.iss_rs2] != '0;
        go = ~rst & bus.iss_valid;
        bus.stall = go & ~bus.flush & (blk1 | blk2);
        bus.iss_ready = go & ~bus.flush & ~(blk1 | blk2);
        bus.fwd_rs1_sel = (go & hit1) ? age_q[bus.iss_rs1] : '0;
        bus.fwd_rs2_sel = (go & hit2) ? age_q[bus.iss_rs2] : '0;
        accept = bus.iss_ready & bus.iss_we & (bus.iss_rd != '0);
        lat_sat = (bus.iss_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : bus.iss_lat;
        for (int r = 0; r < NREGS; r++) begin
            age_d[r] = (age_q[r] == '0 || age_q[r] == STG_W'(PIPE_DEPTH) ||
                        (bus.flush && age_q[r] <= STG_W'(FLUSH_AGE))) ? '0 : age_q[r] + STG_W'(1);
            cnt_d[r] = (age_d[r] == '0 || cnt_q[r] == '0) ? '0 : cnt_q[r] - LAT_W'(1);
            // The issue cycle itself counts toward the latency, so an ALU result (lat=1) never blocks.
            if (accept && bus.iss_rd == RA_W'(r)) begin
                age_d[r] = STG_W'(1);
                cnt_d[r] = (lat_sat == '0) ? '0 : lat_sat - LAT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '{default: '0};
            cnt_q <= '{default: '0};
        end else begin
            age_q <= age_d;
            cnt_q <= cnt_d;
        end
    end
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    assign stall_cnt_d = (bus.stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
    assign bus.stall_cnt = rst ? '0 : stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic against an issue-history model.
module tb_hazard_scoreboard;
    localparam int PD = 3, MAXL = 3, FA = 1;
    logic clk = 1'b0;
    logic rst;
    int checks = 0, passes = 0, cyc = 0, mstat = 0;
    bit mv [32];
    int mt [32];
    int ml [32];
    hazard_scoreboard_if bus ();
    hazard_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Model: a register is in flight for PD cycles after the cycle its write issued.
    function automatic int m_age(input int r);
        return cyc - mt[r];
    endfunction
    function automatic bit m_hit(input int rs, input bit u);
        return u && rs != 0 && mv[rs] && m_age(rs) >= 1 && m_age(rs) <= PD;
    endfunction
    function automatic bit m_blk(input int rs, input bit u);
        return m_hit(rs, u) && m_age(rs) < ((ml[rs] > MAXL) ? MAXL : ml[rs]);
    endfunction
    function automatic bit e_stall();
        return !rst && bus.iss_valid && !bus.flush &&
               (m_blk(int'(bus.iss_rs1), bus.iss_rs1_use) || m_blk(int'(bus.iss_rs2), bus.iss_rs2_use));
    endfunction
    function automatic bit e_ready();
        return !rst && bus.iss_valid && !bus.flush && !e_stall();
    endfunction
    function automatic int e_sel(input int rs, input bit u);
        return (!rst && bus.iss_valid && m_hit(rs, u)) ? m_age(rs) : 0;
    endfunction
    function automatic logic [37:0] expv();
        int sc;
`ifdef HAZARD_STATS_EN
        sc = rst ? 0 : mstat;
`else
        sc = 0;
`endif
        return {e_ready(), e_stall(), 2'(e_sel(int'(bus.iss_rs1), bus.iss_rs1_use)),
                2'(e_sel(int'(bus.iss_rs2), bus.iss_rs2_use)), 32'(sc)};
    endfunction
    function automatic logic [37:0] gotv();
        return {bus.iss_ready, bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel, bus.stall_cnt};
    endfunction

    task automatic drive(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                         input int d, input bit w, input int l, input bit f);
        bus.iss_valid = v; bus.iss_rs1 = 5'(a1); bus.iss_rs1_use = u1;
        bus.iss_rs2 = 5'(a2); bus.iss_rs2_use = u2; bus.iss_rd = 5'(d);
        bus.iss_we = w; bus.iss_lat = 2'(l); bus.flush = f;
        #1;
    endtask

    task automatic tick();
        bit acc;
        int rd;
        @(posedge clk);
        acc = e_ready() && bus.iss_we && bus.iss_rd != 0;
        rd = int'(bus.iss_rd);
        if (rst) begin
            mv = '{default: 0};
            mstat = 0;
        end else begin
            if (e_stall()) mstat++;
            if (bus.flush)
                for (int r = 0; r < 32; r++)
                    if (mv[r] && m_age(r) >= 1 && m_age(r) <= FA) mv[r] = 0;
            if (acc) begin
                mv[rd] = 1; mt[rd] = cyc; ml[rd] = int'(bus.iss_lat);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 1, 6, 1, 7, 1, 2, 0);
        checks++; if (gotv() !== 38'd0) $display("FAIL reset_outputs got %h want 0", gotv()); else passes++;
        tick(); tick();
        rst = 1'b0;
        drive(1, 5, 1, 6, 1, 0, 0, 0, 0);
        checks++; if (gotv() !== expv()) $display("FAIL reset_model got %h want %h", gotv(), expv()); else passes++;
        checks++; if ({bus.iss_ready, bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 6'b100000)
            $display("FAIL reset_idle got %b want 100000", {bus.iss_ready, bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel});
        else passes++;
        tick();
    endtask

    task automatic test_alu_raw();
        int want [4] = '{1, 2, 3, 0};
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
            checks++; if (gotv() !== expv()) $display("FAIL alu_model c%0d got %h want %h", i, gotv(), expv()); else passes++;
            checks++; if (bus.stall !== 1'b0 || bus.fwd_rs1_sel !== 2'(want[i]))
                $display("FAIL alu_sel c%0d got stall=%b sel=%0d want stall=0 sel=%0d", i, bus.stall, bus.fwd_rs1_sel, want[i]);
            else passes++;
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 2, 0);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
        checks++; if (gotv() !== expv()) $display("FAIL load_model1 got %h want %h", gotv(), expv()); else passes++;
        checks++; if (bus.stall !== 1'b1 || bus.iss_ready !== 1'b0)
            $display("FAIL load_stall got stall=%b ready=%b want stall=1 ready=0", bus.stall, bus.iss_ready);
        else passes++;
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
        checks++; if (gotv() !== expv()) $display("FAIL load_model2 got %h want %h", gotv(), expv()); else passes++;
        checks++; if (bus.stall !== 1'b0 || bus.iss_ready !== 1'b1 || bus.fwd_rs2_sel !== 2'd2)
            $display("FAIL load_accept got stall=%b ready=%b sel=%0d want 0 1 2", bus.stall, bus.iss_ready, bus.fwd_rs2_sel);
        else passes++;
        tick();
    endtask

    task automatic test_x0_unused();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 3, 0);
        tick();
        drive(1, 0, 1, 0, 1, 4, 1, 3, 0);
        checks++; if (gotv() !== expv()) $display("FAIL x0_model got %h want %h", gotv(), expv()); else passes++;
        checks++; if ({bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 5'b0)
            $display("FAIL x0_read got stall=%b sel1=%0d sel2=%0d want 0 0 0", bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel);
        else passes++;
        tick();
        drive(1, 0, 0, 4, 0, 0, 0, 0, 0);
        checks++; if (bus.stall !== 1'b0 || bus.iss_ready !== 1'b1 || bus.fwd_rs2_sel !== 2'd0)
            $display("FAIL unused_src got stall=%b ready=%b sel=%0d want 0 1 0", bus.stall, bus.iss_ready, bus.fwd_rs2_sel);
        else passes++;
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 3, 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (gotv() !== expv()) $display("FAIL waw_model got %h want %h", gotv(), expv()); else passes++;
        checks++; if (bus.stall !== 1'b0 || bus.fwd_rs1_sel !== 2'd1)
            $display("FAIL waw_newest got stall=%b sel=%0d want stall=0 sel=1", bus.stall, bus.fwd_rs1_sel);
        else passes++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 9, 1, 2, 0);
        tick();
        drive(1, 9, 1, 0, 0, 10, 1, 1, 1);
        checks++; if (bus.iss_ready !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL flush_issue got ready=%b stall=%b want 0 0", bus.iss_ready, bus.stall);
        else passes++;
        tick();
        drive(1, 9, 1, 10, 1, 0, 0, 0, 0);
        checks++; if (gotv() !== expv()) $display("FAIL flush_model got %h want %h", gotv(), expv()); else passes++;
        checks++; if ({bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 5'b0)
            $display("FAIL flush_idle got stall=%b sel1=%0d sel2=%0d want 0 0 0", bus.stall, bus.fwd_rs1_sel, bus.fwd_rs2_sel);
        else passes++;
        tick();
    endtask

    task automatic test_stats_reset();
        logic [31:0] want_cnt;
`ifdef HAZARD_STATS_EN
        want_cnt = 32'd3;
`else
        want_cnt = 32'd0;
`endif
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 3, 0); tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 8, 1, 3, 0); tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (gotv() !== expv()) $display("FAIL stats_model got %h want %h", gotv(), expv()); else passes++;
        checks++; if (bus.stall_cnt !== want_cnt)
            $display("FAIL stats_count got %0d want %0d", bus.stall_cnt, want_cnt);
        else passes++;
        rst = 1'b1;
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (gotv() !== 38'd0) $display("FAIL stats_rst_outputs got %h want 0", gotv()); else passes++;
        tick();
        rst = 1'b0;
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.stall, bus.fwd_rs1_sel} !== 3'b0 || bus.stall_cnt !== 32'd0)
            $display("FAIL stats_after_rst got stall=%b sel=%0d cnt=%0d want 0 0 0", bus.stall, bus.fwd_rs1_sel, bus.stall_cnt);
        else passes++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            checks++; if (gotv() !== expv()) $display("FAIL random c%0d got %h want %h", i, gotv(), expv()); else passes++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_raw();
        test_load_use();
        test_x0_unused();
        test_waw();
        test_flush();
        test_stats_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
